// File: rtl/cmd_ctrl.sv
// Two-button command front end: synchronise, debounce and edge-detect each button,
// then turn every fresh press into a fixed-length command on cmd/cmd_valid.
module cmd_ctrl #(
    parameter int DB_CYCLES   = 16,
    parameter int HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] btn,
    output logic [1:0] cmd,
    output logic       cmd_valid
);

    localparam int            CW        = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_MAX    = CW'(DB_CYCLES - 1);
    localparam logic [7:0]    HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    logic [1:0]         r_sync1;
    logic [1:0]         r_sync2;
    logic [1:0]         r_db;
    logic [1:0]         r_db_prev;
    logic [1:0]         w_db_nxt;
    logic [1:0]         w_press;
    logic [1:0][CW-1:0] r_cnt;
    logic [1:0][CW-1:0] w_cnt_nxt;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_hcnt;
    logic [7:0]         w_hcnt_nxt;
    logic [1:0]         r_cmd;
    logic [1:0]         w_cmd_nxt;
    logic               r_cmd_valid;
    logic               w_cmd_valid_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 2'b00;
            r_sync2   <= 2'b00;
            r_db      <= 2'b00;
            r_db_prev <= 2'b00;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= btn;
            r_sync2   <= r_sync1;
            r_db      <= w_db_nxt;
            r_db_prev <= r_db;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // The debounced level flips only after DB_CYCLES consecutive disagreeing samples.
    always_comb begin
        w_db_nxt  = r_db;
        w_cnt_nxt = r_cnt;
        for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_db[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] == DB_MAX) begin
                w_db_nxt[i]  = ~r_db[i];
                w_cnt_nxt[i] = '0;
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + CW'(1'b1);
            end
        end
    end

    assign w_press = r_db & ~r_db_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hcnt      <= 8'd0;
            r_cmd       <= 2'b00;
            r_cmd_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hcnt      <= w_hcnt_nxt;
            r_cmd       <= w_cmd_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
        end
    end

    // Presses seen while holding are dropped, never queued.
    always_comb begin
        w_state_nxt     = r_state;
        w_hcnt_nxt      = r_hcnt;
        w_cmd_nxt       = r_cmd;
        w_cmd_valid_nxt = r_cmd_valid;
        case (r_state)
            S_IDLE: begin
                if (|w_press) begin
                    w_state_nxt     = S_HOLD;
                    w_hcnt_nxt      = HOLD_LOAD;
                    w_cmd_nxt       = r_db;
                    w_cmd_valid_nxt = 1'b1;
                end else begin
                    w_hcnt_nxt      = 8'd0;
                    w_cmd_nxt       = 2'b00;
                    w_cmd_valid_nxt = 1'b0;
                end
            end
            S_HOLD: begin
                if (r_hcnt == 8'd0) begin
                    w_state_nxt     = S_IDLE;
                    w_cmd_nxt       = 2'b00;
                    w_cmd_valid_nxt = 1'b0;
                end else begin
                    w_hcnt_nxt = r_hcnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_hcnt_nxt      = 8'd0;
                w_cmd_nxt       = 2'b00;
                w_cmd_valid_nxt = 1'b0;
            end
        endcase
    end

    assign cmd       = r_cmd;
    assign cmd_valid = r_cmd_valid;

endmodule
